// File: rtl/adaptive_filter_ctrl.sv
// adaptive_filter_ctrl
//   Timing and sequencing controller for the receive adaptive equalizer
//   (FSE + LMS + rate-1 downsampler + slicer). Derives the T/2 and T strobes
//   from the system clock at a programmable sampling phase and runs the
//   start-up sequence IDLE -> FLUSH -> ADAPT <-> HOLD.
//
// Ports
//   clk           system clock
//   i_reset_n     asynchronous active-low reset (release synchronised here)
//   i_enable      run receiver; low returns to IDLE (highest priority)
//   i_phase       rate-1 strobe position in the symbol, taken modulo OS_FACTOR
//   i_freeze      hold LMS taps (ADAPT <-> HOLD)
//   o_en_rx       equalizer global enable (FLUSH/ADAPT/HOLD)
//   o_en_rate2    T/2 strobe
//   o_en_rate1    T strobe
//   o_save_shtrs  LMS shift-register capture strobe (rate-1 strobe in ADAPT)
//   o_en_adapt    LMS tap update enable (ADAPT only)
//   o_locked      training complete, sticky until IDLE/reset
//   o_state       IDLE=0, FLUSH=1, ADAPT=2, HOLD=3
//   o_sym_cnt     rate-1 strobes counted in ADAPT/HOLD, saturating
module adaptive_filter_ctrl #(
  parameter int unsigned OS_FACTOR  = 4,
  parameter int unsigned PHASE_W    = 2,
  parameter int unsigned FLUSH_SYMS = 5,
  parameter int unsigned TRAIN_SYMS = 1024,
  parameter int unsigned NB_SYM_CNT = 16
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic [PHASE_W-1:0]    i_phase,
  input  logic                  i_freeze,
  output logic                  o_en_rx,
  output logic                  o_en_rate2,
  output logic                  o_en_rate1,
  output logic                  o_save_shtrs,
  output logic                  o_en_adapt,
  output logic                  o_locked,
  output logic [1:0]            o_state,
  output logic [NB_SYM_CNT-1:0] o_sym_cnt
);

  localparam int unsigned HALF = OS_FACTOR / 2;
  localparam int unsigned FL_W = (FLUSH_SYMS > 1) ? $clog2(FLUSH_SYMS) : 1;
  localparam logic [PHASE_W-1:0] CNT_LAST = PHASE_W'(OS_FACTOR - 1);
  localparam logic [FL_W-1:0]    FL_LAST  = FL_W'(FLUSH_SYMS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_ADAPT = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [PHASE_W-1:0]      cnt_q, cnt_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [PHASE_W-1:0]      phase_in, phase_b;
  logic [FL_W-1:0]         flush_cnt_q, flush_cnt_d;
  logic [NB_SYM_CNT-1:0]   sym_cnt_q, sym_cnt_d;
  logic                    locked_q, locked_d;
  logic                    en_rx_q, en_rx_d;
  logic                    en_rate1_q, en_rate1_d;
  logic                    en_rate2_q, en_rate2_d;
  logic                    save_q, save_d;
  logic                    adapt_q, adapt_d;
  logic                    run_d;
  logic                    rst_meta_q, rst_sync_q;

  // Reset synchroniser: assertion passes through asynchronously, release is
  // delayed two clock edges so all downstream flops leave reset together.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the flush exit uses the registered strobe so ADAPT
  // starts the cycle after the last flush strobe.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_enable) state_d = S_FLUSH;
      S_FLUSH: if (en_rate1_q && (flush_cnt_q == FL_LAST))
                 state_d = i_freeze ? S_HOLD : S_ADAPT;
      S_ADAPT: if (i_freeze) state_d = S_HOLD;
      S_HOLD:  if (!i_freeze) state_d = S_ADAPT;
      default: state_d = S_IDLE;
    endcase
    if (!i_enable) state_d = S_IDLE;
  end

  // Output / datapath next values. Every output is computed from the
  // next-cycle state, counter and phase so the registered outputs line up
  // with the state they describe.
  always_comb begin
    phase_in = PHASE_W'(32'(i_phase) % OS_FACTOR);

    if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PHASE_W'(1);
    end

    // New phase only takes effect at a symbol boundary, so a change cannot
    // split or double a symbol.
    if ((state_q == S_IDLE) || (cnt_q == CNT_LAST)) begin
      phase_d = phase_in;
    end else begin
      phase_d = phase_q;
    end
    phase_b = PHASE_W'((32'(phase_d) + HALF) % OS_FACTOR);

    run_d      = (state_d != S_IDLE);
    en_rx_d    = run_d;
    en_rate1_d = run_d && (cnt_d == phase_d);
    en_rate2_d = run_d && ((cnt_d == phase_d) || (cnt_d == phase_b));
    adapt_d    = (state_d == S_ADAPT);
    save_d     = en_rate1_d && (state_d == S_ADAPT);

    if (state_d != S_FLUSH) begin
      flush_cnt_d = '0;
    end else if ((state_q == S_FLUSH) && en_rate1_q) begin
      flush_cnt_d = flush_cnt_q + FL_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end

    if ((state_d == S_IDLE) || (state_d == S_FLUSH)) begin
      sym_cnt_d = '0;
    end else if (((state_q == S_ADAPT) || (state_q == S_HOLD)) && en_rate1_q &&
                 (sym_cnt_q != '1)) begin
      sym_cnt_d = sym_cnt_q + NB_SYM_CNT'(1);
    end else begin
      sym_cnt_d = sym_cnt_q;
    end

    if (state_d == S_IDLE) begin
      locked_d = 1'b0;
    end else if ((state_q == S_ADAPT) && (32'(sym_cnt_q) >= TRAIN_SYMS)) begin
      locked_d = 1'b1;
    end else begin
      locked_d = locked_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      cnt_q       <= '0;
      phase_q     <= '0;
      flush_cnt_q <= '0;
      sym_cnt_q   <= '0;
      locked_q    <= 1'b0;
      en_rx_q     <= 1'b0;
      en_rate1_q  <= 1'b0;
      en_rate2_q  <= 1'b0;
      save_q      <= 1'b0;
      adapt_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      flush_cnt_q <= flush_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      locked_q    <= locked_d;
      en_rx_q     <= en_rx_d;
      en_rate1_q  <= en_rate1_d;
      en_rate2_q  <= en_rate2_d;
      save_q      <= save_d;
      adapt_q     <= adapt_d;
    end
  end

  assign o_en_rx      = en_rx_q;
  assign o_en_rate2   = en_rate2_q;
  assign o_en_rate1   = en_rate1_q;
  assign o_save_shtrs = save_q;
  assign o_en_adapt   = adapt_q;
  assign o_locked     = locked_q;
  assign o_state      = state_q;
  assign o_sym_cnt    = sym_cnt_q;

endmodule

// File: tb/tb_adaptive_filter_ctrl.sv
// Testbench for adaptive_filter_ctrl: randomized and directed stimulus
// checked cycle by cycle against a timeline-style reference model.
module tb_adaptive_filter_ctrl;

  localparam int OS = 4;
  localparam int PW = 3;
  localparam int FL = 5;
  localparam int TR = 8;
  localparam int SW = 4;
  localparam int SYM_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          frz;
  logic [PW-1:0] ph;
  logic          o_en_rx, o_en_rate2, o_en_rate1, o_save_shtrs, o_en_adapt, o_locked;
  logic [1:0]    o_state;
  logic [SW-1:0] o_sym_cnt;
  logic [11:0]   dut_vec;

  always #5 clk = ~clk;

  adaptive_filter_ctrl #(
    .OS_FACTOR (OS),
    .PHASE_W   (PW),
    .FLUSH_SYMS(FL),
    .TRAIN_SYMS(TR),
    .NB_SYM_CNT(SW)
  ) dut (
    .clk         (clk),
    .i_reset_n   (rst_n),
    .i_enable    (en),
    .i_phase     (ph),
    .i_freeze    (frz),
    .o_en_rx     (o_en_rx),
    .o_en_rate2  (o_en_rate2),
    .o_en_rate1  (o_en_rate1),
    .o_save_shtrs(o_save_shtrs),
    .o_en_adapt  (o_en_adapt),
    .o_locked    (o_locked),
    .o_state     (o_state),
    .o_sym_cnt   (o_sym_cnt)
  );

  assign dut_vec = {o_en_rx, o_en_rate2, o_en_rate1, o_save_shtrs, o_en_adapt,
                    o_locked, o_state, o_sym_cnt};

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: mode, absolute cycle of the first FLUSH cycle, the
  // sampling phase in force, and event counts.
  int cyc = 0;
  int m_st, m_t0, m_ph, m_fl, m_sym, m_lock;

  task automatic model_reset();
    m_st = 0; m_t0 = 0; m_ph = 0; m_fl = 0; m_sym = 0; m_lock = 0;
  endtask

  function automatic int m_pos();
    if (m_st == 0) return 0;
    return (cyc - m_t0) % OS;
  endfunction

  function automatic logic m_r1();
    return (m_st != 0) && (m_pos() == m_ph);
  endfunction

  function automatic logic [11:0] exp_vec();
    logic run, r1, r2;
    run = (m_st != 0);
    r1  = m_r1();
    r2  = run && ((m_pos() % (OS / 2)) == (m_ph % (OS / 2)));
    return {run, r2, r1, r1 && (m_st == 2), m_st == 2, m_lock != 0,
            2'(m_st), 4'(m_sym)};
  endfunction

  task automatic model_update();
    logic r1;
    int   pos, ns;
    if (!rst_n) begin
      model_reset();
      cyc++;
      return;
    end
    r1  = m_r1();
    pos = m_pos();
    if (!en) ns = 0;
    else if (m_st == 0) ns = 1;
    else if (m_st == 1) ns = (r1 && (m_fl + 1 == FL)) ? (frz ? 3 : 2) : 1;
    else ns = frz ? 3 : 2;
    if (m_st == 0) begin
      m_ph = int'(ph) % OS;
      m_t0 = cyc + 1;
    end else if (pos == OS - 1) begin
      m_ph = int'(ph) % OS;
    end
    if (ns == 0) m_lock = 0;
    else if (m_st == 2 && m_sym >= TR) m_lock = 1;
    if (ns <= 1) m_sym = 0;
    else if (m_st >= 2 && r1 && m_sym < SYM_MAX) m_sym++;
    if (ns != 1) m_fl = 0;
    else if (r1) m_fl++;
    m_st = ns;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; frz = 1'b0; ph = '0;
    model_reset();
    tick(); tick();
    n_chk++;
    if (dut_vec !== 12'h000) $display("FAIL reset_outputs got=%h want=000", dut_vec);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_startup(input string tag);
    int t_en, f_r1, f_r2, f_ad;
    ph = PW'(1); en = 1'b1; frz = 1'b0;
    tick();
    t_en = cyc;
    n_chk++;
    if (o_en_rx !== 1'b1 || o_state !== 2'd1)
      $display("FAIL %s_first_cycle en_rx=%b state=%0d want en_rx=1 state=1", tag, o_en_rx, o_state);
    else n_pass++;
    f_r1 = -1; f_r2 = -1; f_ad = -1;
    for (int i = 0; i < 30; i++) begin
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL %s_cycle cyc=%0d got=%h want=%h", tag, cyc, dut_vec, exp_vec());
      else n_pass++;
      if (o_en_rate1 && f_r1 < 0) f_r1 = cyc - t_en;
      if (o_en_rate2 && f_r2 < 0) f_r2 = cyc - t_en;
      if (o_state == 2'd2 && f_ad < 0) f_ad = cyc - t_en;
      tick();
    end
    n_chk++;
    if (f_r1 !== 1) $display("FAIL %s_first_rate1 offset=%0d want=1", tag, f_r1); else n_pass++;
    n_chk++;
    if (f_r2 !== 1) $display("FAIL %s_first_rate2 offset=%0d want=1", tag, f_r2); else n_pass++;
    n_chk++;
    if (f_ad !== 18) $display("FAIL %s_flush_exit offset=%0d want=18", tag, f_ad); else n_pass++;
  endtask

  task automatic test_freeze();
    int guard, sym_a, bad;
    guard = 0;
    while (!o_en_rate1 && guard < 8) begin tick(); guard++; end
    n_chk++;
    if (o_en_rate1 !== 1'b1) $display("FAIL freeze_align rate1=%b want=1", o_en_rate1); else n_pass++;
    frz = 1'b1;
    tick();
    n_chk++;
    if (o_state !== 2'd3 || o_en_adapt !== 1'b0)
      $display("FAIL freeze_enter state=%0d adapt=%b want state=3 adapt=0", o_state, o_en_adapt);
    else n_pass++;
    sym_a = int'(o_sym_cnt);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL freeze_cycle cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
      else n_pass++;
      if (o_en_adapt || o_save_shtrs || o_state != 2'd3) bad++;
      if (i < 11) tick();
    end
    frz = 1'b0;
    tick();
    n_chk++;
    if (bad != 0) $display("FAIL freeze_gating bad_cycles=%0d want=0", bad); else n_pass++;
    n_chk++;
    if (int'(o_sym_cnt) - sym_a != 3) $display("FAIL freeze_sym_delta got=%0d want=3", int'(o_sym_cnt) - sym_a);
    else n_pass++;
    n_chk++;
    if (o_state !== 2'd2) $display("FAIL freeze_release state=%0d want=2", o_state); else n_pass++;
  endtask

  task automatic test_phase_change();
    int last1, last2, n6, nbad, nbad2;
    last1 = -1; last2 = -1; n6 = 0; nbad = 0; nbad2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) ph = PW'(3);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL phase_cycle cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
      else n_pass++;
      if (o_en_rate1) begin
        if (last1 >= 0) begin
          if (cyc - last1 == 6) n6++;
          else if (cyc - last1 != 4) nbad++;
        end
        last1 = cyc;
      end
      if (o_en_rate2) begin
        if (last2 >= 0 && cyc - last2 != 2) nbad2++;
        last2 = cyc;
      end
      tick();
    end
    n_chk++;
    if (nbad != 0) $display("FAIL phase_rate1_interval bad=%0d want=0", nbad); else n_pass++;
    n_chk++;
    if (n6 != 1) $display("FAIL phase_shift_count got=%0d want=1", n6); else n_pass++;
    n_chk++;
    if (nbad2 != 0) $display("FAIL phase_rate2_interval bad=%0d want=0", nbad2); else n_pass++;
  endtask

  task automatic test_lock();
    int guard, bad;
    en = 1'b0;
    tick();
    n_chk++;
    if (o_locked !== 1'b0 || o_sym_cnt !== '0 || dut_vec !== 12'h000)
      $display("FAIL disable_clear got=%h want=000", dut_vec);
    else n_pass++;
    ph = PW'($urandom_range(0, 7));
    en = 1'b1;
    guard = 0;
    while (o_sym_cnt != SW'(TR) && guard < 200) begin
      tick(); guard++;
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL lock_cycle cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (o_sym_cnt !== SW'(TR) || o_locked !== 1'b0)
      $display("FAIL lock_reach sym=%0d locked=%b want sym=%0d locked=0", o_sym_cnt, o_locked, TR);
    else n_pass++;
    tick();
    n_chk++;
    if (o_locked !== 1'b1) $display("FAIL lock_set locked=%b want=1", o_locked); else n_pass++;
    frz = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_locked !== 1'b1) bad++;
    end
    n_chk++;
    if (bad != 0 || o_state !== 2'd3) $display("FAIL lock_hold bad=%0d state=%0d want bad=0 state=3", bad, o_state);
    else n_pass++;
    frz = 1'b0;
    guard = 0;
    while (o_sym_cnt != SW'(SYM_MAX) && guard < 100) begin tick(); guard++; end
    for (int i = 0; i < 10; i++) tick();
    n_chk++;
    if (o_sym_cnt !== SW'(SYM_MAX) || dut_vec !== exp_vec())
      $display("FAIL sym_saturate sym=%0d want=%0d vec=%h/%h", o_sym_cnt, SYM_MAX, dut_vec, exp_vec());
    else n_pass++;
    en = 1'b0;
    tick();
    n_chk++;
    if (dut_vec !== 12'h000) $display("FAIL lock_clear got=%h want=000", dut_vec); else n_pass++;
  endtask

  task automatic test_async_reset();
    ph = PW'(1); en = 1'b1; frz = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL areset_run cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (o_state !== 2'd2) $display("FAIL areset_pre state=%0d want=2", o_state); else n_pass++;
    #3;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    n_chk++;
    if (dut_vec !== 12'h000) $display("FAIL areset_immediate got=%h want=000", dut_vec); else n_pass++;
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL areset_release cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
      else n_pass++;
    end
    test_startup("restart");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (!en) begin
        if ($urandom_range(0, 3) == 0) en = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        en = 1'b0;
      end
      if ($urandom_range(0, 29) == 0) frz = ~frz;
      if ($urandom_range(0, 19) == 0) ph = PW'($urandom_range(0, 7));
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL random_cycle cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; frz = 1'b0; ph = '0;
    model_reset();
    test_reset();
    test_startup("start");
    test_freeze();
    test_phase_change();
    test_lock();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
